// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and select decode for the I/O read-data path
// Contents:
//   STAT_OVF_BIT   bit position of the sticky overflow flag in a status read
//   sel_e          winning region of a read access (priority encoded)
//   kb_valid_pos   bit position of the valid flag in a keyboard data read (= KB_W)
//   sel_decode     switch > keyboard > status > memory priority encoder
package io_pkg;

  localparam int STAT_OVF_BIT = 15;

  typedef enum logic [1:0] {
    SEL_MEM      = 2'd0,
    SEL_STATUS   = 2'd1,
    SEL_KEYBOARD = 2'd2,
    SEL_SWITCH   = 2'd3
  } sel_e;

  // The valid flag sits directly above the scan code.
  function automatic int kb_valid_pos(input int kb_w);
    return kb_w;
  endfunction

  function automatic sel_e sel_decode(input logic switch_cs,
                                      input logic keyboard_cs,
                                      input logic status_cs);
    if (switch_cs)        return SEL_SWITCH;
    else if (keyboard_cs) return SEL_KEYBOARD;
    else if (status_cs)   return SEL_STATUS;
    else                  return SEL_MEM;
  endfunction

endpackage

// File: rtl/io_kb_fifo.sv
// rtl/io_kb_fifo.sv - keyboard scan-code FIFO with sticky overflow
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push          push strobe (kb_valid)
//   push_data     scan code to push
//   pop           qualified pop request (ignored when empty)
//   ovf_clr       qualified status read, clears overflow
//   head          oldest entry, 0 when empty
//   valid         FIFO non-empty
//   count         fill level, 0..KB_DEPTH
//   overflow      sticky overflow flag
module io_kb_fifo #(
  parameter int KB_W     = 8,
  parameter int KB_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [KB_W-1:0]           push_data,
  input  logic                      pop,
  input  logic                      ovf_clr,
  output logic [KB_W-1:0]           head,
  output logic                      valid,
  output logic [$clog2(KB_DEPTH):0] count,
  output logic                      overflow
);

  localparam int PW = $clog2(KB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(KB_DEPTH);

  logic [KB_W-1:0] mem [KB_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  // Pointers are exactly PW bits wide, so wrap is the natural binary rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A new drop wins over a clearing status read in the same cycle.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: nothing is read from it while count is 0.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

  assign head     = empty ? '0 : mem[rd_ptr];
  assign valid    = ~empty;
  assign count    = cnt;
  assign overflow = ovf;

endmodule

// File: rtl/io_rd_mux.sv
// rtl/io_rd_mux.sv - CPU read-data selector for switch, keyboard and memory regions
// Option macro: IO_SW_SYNC_EN (two-flop switch synchroniser; raw switches when undefined)
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   switch_cs     switch region selected
//   keyboard_cs   keyboard data region selected
//   status_cs     keyboard status region selected
//   rd_en         CPU load commits this cycle; qualifies pop and overflow clear
//   sw            raw switch inputs
//   kb_data       scan code from keyboard controller
//   kb_valid      one-cycle push strobe for kb_data
//   data          data-memory read data
//   data_sel      selected read data (combinational)
//   kb_irq        high while the keyboard FIFO holds codes
module io_rd_mux
  import io_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SW_W     = 16,
  parameter int KB_W     = 8,
  parameter int KB_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch_cs,
  input  logic              keyboard_cs,
  input  logic              status_cs,
  input  logic              rd_en,
  input  logic [SW_W-1:0]   sw,
  input  logic [KB_W-1:0]   kb_data,
  input  logic              kb_valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_sel,
  output logic              kb_irq
);

  localparam int CW           = $clog2(KB_DEPTH) + 1;
  localparam int KB_VALID_BIT = kb_valid_pos(KB_W);

  sel_e            sel;
  logic            kb_pop;
  logic            ovf_clr;
  logic [KB_W-1:0] kb_head;
  logic            kb_nonempty;
  logic [CW-1:0]   kb_count;
  logic            kb_ovf;
  logic [SW_W-1:0] sw_q;

  // Only the winning region may cause a side effect.
  assign sel     = sel_decode(switch_cs, keyboard_cs, status_cs);
  assign kb_pop  = rd_en & (sel == SEL_KEYBOARD);
  assign ovf_clr = rd_en & (sel == SEL_STATUS);

`ifdef IO_SW_SYNC_EN
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  assign sw_q = sw_sync;
`else
  assign sw_q = sw;
`endif

  io_kb_fifo #(
    .KB_W     (KB_W),
    .KB_DEPTH (KB_DEPTH)
  ) u_kb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (kb_valid),
    .push_data (kb_data),
    .pop       (kb_pop),
    .ovf_clr   (ovf_clr),
    .head      (kb_head),
    .valid     (kb_nonempty),
    .count     (kb_count),
    .overflow  (kb_ovf)
  );

  always_comb begin
    data_sel = '0;
    unique case (sel)
      SEL_SWITCH: begin
        data_sel[SW_W-1:0] = sw_q;
      end
      SEL_KEYBOARD: begin
        data_sel[KB_VALID_BIT] = kb_nonempty;
        data_sel[KB_W-1:0]     = kb_head;
      end
      SEL_STATUS: begin
        data_sel[STAT_OVF_BIT] = kb_ovf;
        data_sel[CW-1:0]       = kb_count;
      end
      default: begin
        data_sel = data;
      end
    endcase
  end

  // Derived from the registered count only, so it changes just after clock edges.
  assign kb_irq = kb_nonempty;

endmodule

// File: tb/tb_io_rd_mux.sv
// tb/tb_io_rd_mux.sv - self-checking bench for io_rd_mux against a queue-based model
module tb_io_rd_mux;

  localparam int DW    = 32;
  localparam int SWW   = 16;
  localparam int KW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          switch_cs;
  logic          keyboard_cs;
  logic          status_cs;
  logic          rd_en;
  logic [SWW-1:0] sw;
  logic [KW-1:0] kb_data;
  logic          kb_valid;
  logic [DW-1:0] data;
  logic [DW-1:0] data_sel;
  logic          kb_irq;

  int total = 0;
  int bad   = 0;

  logic [KW-1:0]  q [$];
  bit             m_ovf;
  logic [SWW-1:0] m_sw1;
  logic [SWW-1:0] m_sw2;

  io_rd_mux #(
    .DATA_W   (DW),
    .SW_W     (SWW),
    .KB_W     (KW),
    .KB_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .switch_cs   (switch_cs),
    .keyboard_cs (keyboard_cs),
    .status_cs   (status_cs),
    .rd_en       (rd_en),
    .sw          (sw),
    .kb_data     (kb_data),
    .kb_valid    (kb_valid),
    .data        (data),
    .data_sel    (data_sel),
    .kb_irq      (kb_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_sel();
    logic [SWW-1:0] swv;
`ifdef IO_SW_SYNC_EN
    swv = m_sw2;
`else
    swv = sw;
`endif
    if (switch_cs)   return {16'h0, swv};
    if (keyboard_cs) return (q.size() > 0) ? (32'h100 | {24'h0, q[0]}) : 32'h0;
    if (status_cs)   return (m_ovf ? 32'h8000 : 32'h0) + 32'(q.size());
    return data;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour at a rising edge, from the read/push rules.
  task automatic model_edge();
    bit pop;
    bit clr;
    bit ovf_set;
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_sw1 = '0;
      m_sw2 = '0;
      return;
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
    pop = rd_en && !switch_cs && keyboard_cs && (q.size() > 0);
    clr = rd_en && !switch_cs && !keyboard_cs && status_cs;
    ovf_set = 0;
    if (pop) void'(q.pop_front());
    if (kb_valid) begin
      if (q.size() < DEPTH) q.push_back(kb_data);
      else ovf_set = 1;
    end
    if (ovf_set)  m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic step(input string tag, input logic sc, input logic kc, input logic tc,
                      input logic re, input logic [SWW-1:0] s, input logic [KW-1:0] kd,
                      input logic kv, input logic [DW-1:0] d);
    switch_cs   = sc;
    keyboard_cs = kc;
    status_cs   = tc;
    rd_en       = re;
    sw          = s;
    kb_data     = kd;
    kb_valid    = kv;
    data        = d;
    #1;
    check(tag, data_sel, exp_sel());
    check({tag, "_irq"}, {31'b0, kb_irq}, {31'b0, q.size() != 0});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic push(input logic [KW-1:0] code);
    step("push", 0, 0, 0, 0, 16'h0, code, 1, 32'hDEADBEEF);
  endtask

  initial begin
    rst = 1'b1;
    switch_cs = 0; keyboard_cs = 0; status_cs = 0; rd_en = 0;
    sw = '0; kb_data = '0; kb_valid = 0; data = '0;
    q.delete(); m_ovf = 0; m_sw1 = '0; m_sw2 = '0;
    @(negedge clk);

    // Reset state
    step("rst_mem", 0, 0, 0, 0, 16'h0, 8'h0, 0, 32'hDEADBEEF);
    step("rst_kb",  0, 1, 0, 1, 16'h0, 8'h0, 0, 32'hDEADBEEF);
    rst = 1'b0;
    step("mem", 0, 0, 0, 0, 16'h0, 8'h0, 0, 32'hDEADBEEF);
    step("kb_empty", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);

    // Switch read (latency depends on synchroniser option)
    for (int i = 0; i < 3; i++) step("sw", 1, 0, 0, 0, 16'hA5A5, 8'h0, 0, 32'h0);

    // Two pushes, then three keyboard reads
    push(8'h1C);
    push(8'h32);
    step("kb_rd0", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);
    step("kb_rd1", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);
    step("kb_rd2", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);
    step("stat_empty", 0, 0, 1, 0, 16'h0, 8'h0, 0, 32'h0);

    // Overflow: DEPTH+1 pushes, clearing status read, then drain
    for (int i = 0; i <= DEPTH; i++) push(8'h40 + 8'(i));
    step("stat_ovf", 0, 0, 1, 1, 16'h0, 8'h0, 0, 32'h0);
    step("stat_clr", 0, 0, 1, 1, 16'h0, 8'h0, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) step("drain_ovf", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);

    // Push and pop together on a full FIFO
    for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i));
    step("full_pp", 0, 1, 0, 1, 16'h0, 8'hEE, 1, 32'h0);
    step("full_stat", 0, 0, 1, 0, 16'h0, 8'h0, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) step("drain_pp", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);
    step("pp_empty", 0, 0, 1, 0, 16'h0, 8'h0, 0, 32'h0);

    // Overflow set and clearing read in the same cycle: overflow stays set
    for (int i = 0; i < DEPTH; i++) push(8'h70 + 8'(i));
    step("ovf_clr_set", 0, 0, 1, 1, 16'h0, 8'h99, 1, 32'h0);
    step("ovf_kept", 0, 0, 1, 1, 16'h0, 8'h0, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) step("drain_cs", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);

    // Switch beats keyboard: no pop
    push(8'hA1);
    push(8'hA2);
    for (int i = 0; i < 3; i++) step("collide", 1, 1, 0, 1, 16'h1234, 8'h0, 0, 32'h0);
    step("collide_stat", 0, 0, 1, 0, 16'h1234, 8'h0, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] cs;
      cs = 3'($urandom_range(0, 7));
      step("rand", cs[0], cs[1], cs[2], 1'($urandom), 16'($urandom), 8'($urandom),
           1'($urandom), $urandom);
    end

    // Asynchronous reset in the middle of filling
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    switch_cs = 0; keyboard_cs = 0; status_cs = 1; rd_en = 0; kb_valid = 0;
    #1;
    rst = 1'b1;
    q.delete();
    m_ovf = 0;
    #1;
    check("async_rst_stat", data_sel, 32'h0);
    check("async_rst_irq", {31'b0, kb_irq}, 32'h0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;
    push(8'hC5);
    step("post_rst_kb", 0, 1, 0, 1, 16'h0, 8'h0, 0, 32'h0);
    step("post_rst_stat", 0, 0, 1, 0, 16'h0, 8'h0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
